// File: rtl/bus_responder_if.sv
// Request/ack handshake plus the shared 2-bit data bus between the masters
// and the responder.
interface bus_responder_if #(
  parameter int N_MASTERS = 4
) ();
  logic [N_MASTERS-1:0] req;
  logic [1:0]           bus_data;
  logic [N_MASTERS-1:0] ack;

  modport master (output req, output bus_data, input ack);
  modport slave  (input req, input bus_data, output ack);
endinterface

// File: rtl/bus_responder.sv
// Round-robin responder: grants one master per tenure with a one-hot ack and
// captures every beat it drives into a tagged first-word-fall-through FIFO.
module bus_responder #(
  parameter int N_MASTERS = 4,
  parameter int DEPTH     = 8,
  parameter int MAX_BEATS = 4,
  parameter int ID_W      = $clog2(N_MASTERS)
) (
  input  logic                   clk,
  input  logic                   reset,
  bus_responder_if.slave         bus,
  input  logic                   rd_en,
  output logic [1:0]             rd_data,
  output logic [ID_W-1:0]        rd_id,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, DRAIN = 2'd2} state_t;

  state_t               state, state_next;
  logic [ID_W-1:0]      owner, owner_next, rr_ptr, rr_next;
  logic [BW-1:0]        beat_cnt, beat_next;
  logic [CW-1:0]        credits, count_next;
  logic [N_MASTERS-1:0] ack, ack_next;
  logic                 grant, drive_q, push, pop, has_credit;
  logic [ID_W:0]        pick;
  logic [ID_W+1:0]      mem [DEPTH];
  logic [ID_W+1:0]      head;
  logic [AW-1:0]        wr_ptr, rd_ptr;

  // First requesting master after rr_ptr (wrapping); MSB flags a hit.
  function automatic logic [ID_W:0] pick_first(input logic [N_MASTERS-1:0] r,
                                               input logic [ID_W-1:0] p);
    logic [ID_W:0] res;
    int k;
    res = '0;
    for (int i = N_MASTERS; i >= 1; i--) begin
      k = (int'(p) + i) % N_MASTERS;
      if (r[k[ID_W-1:0]]) begin
        res = {1'b1, k[ID_W-1:0]};
      end
    end
    return res;
  endfunction

  assign pick       = pick_first(bus.req, rr_ptr);
  assign has_credit = (credits != CW'(0));
  assign push       = drive_q;
  assign pop        = rd_en && !empty;
  assign bus.ack    = ack;
  assign head       = mem[rd_ptr];
  assign rd_data    = head[1:0];
  assign rd_id      = head[ID_W+1:2];

  // FSM state, grant register, capture pipeline and credit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= ID_W'(N_MASTERS - 1);
      beat_cnt <= '0;
      ack      <= '0;
      drive_q  <= 1'b0;
      credits  <= CW'(DEPTH);
    end else begin
      state    <= state_next;
      owner    <= owner_next;
      rr_ptr   <= rr_next;
      beat_cnt <= beat_next;
      ack      <= ack_next;
      drive_q  <= |ack;
      case ({grant, pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  // Next-state logic; grant means ack stays or goes high for the next cycle.
  always_comb begin
    state_next = state;
    owner_next = owner;
    rr_next    = rr_ptr;
    beat_next  = beat_cnt;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        if (pick[ID_W] && has_credit) begin
          owner_next = pick[ID_W-1:0];
          beat_next  = BW'(1);
          grant      = 1'b1;
          state_next = GRANT;
        end else begin
          state_next = IDLE;
        end
      end
      GRANT: begin
        if (bus.req[owner] && (beat_cnt < BW'(MAX_BEATS)) && has_credit) begin
          beat_next = beat_cnt + BW'(1);
          grant     = 1'b1;
        end else begin
          state_next = DRAIN;
        end
      end
      // Bus turnaround: the last beat lands at this edge, no new grant.
      DRAIN: begin
        rr_next    = owner;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode: one-hot ack for the cycle after the edge.
  always_comb begin
    ack_next = '0;
    if (grant) begin
      ack_next[owner_next] = 1'b1;
    end else begin
      ack_next = '0;
    end
  end

  // FIFO storage and pointers; credits guarantee a push never meets a full FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= {owner, bus.bus_data};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Occupancy for the next cycle.
  always_comb begin
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Registered occupancy flags, derived from the same next value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      count <= count_next;
      empty <= (count_next == CW'(0));
      full  <= (count_next == CW'(DEPTH));
    end
  end
endmodule

// File: tb/tb_bus_responder.sv
// Randomized bench: a cycle-level reference model of arbitration, credits and
// occupancy feeds a scoreboard queue that an independent pop monitor drains.
module tb_bus_responder;
  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam int MAXB  = 4;

  logic       clk;
  logic       reset;
  logic       rd_en;
  logic [1:0] rd_data;
  logic [1:0] rd_id;
  logic       empty;
  logic       full;
  logic [3:0] count;

  bus_responder_if #(.N_MASTERS(N)) bus ();

  bus_responder #(.N_MASTERS(N), .DEPTH(DEPTH), .MAX_BEATS(MAXB), .ID_W(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .rd_en  (rd_en),
    .rd_data(rd_data),
    .rd_id  (rd_id),
    .empty  (empty),
    .full   (full),
    .count  (count)
  );

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  logic [1:0] data_q[$];
  logic [1:0] drive_val = 2'b00;

  // reference model state
  int m_own   = 0;
  bit m_on    = 1'b0;
  bit m_prev  = 1'b0;
  bit m_drain = 1'b0;
  int m_cnt   = 0;
  int m_cred  = DEPTH;
  int m_beats = 0;
  int m_last  = N - 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // the granted master drives its beat in the cycle after it sees ack
  always @(posedge clk) begin
    #1;
    bus.bus_data = drive_val;
  end

  always @(negedge clk) begin : model
    logic [3:0] exp_ack;
    logic [1:0] d;
    bit pop, push, grant;
    int k;
    if (reset) begin
      m_own = 0; m_on = 1'b0; m_prev = 1'b0; m_drain = 1'b0;
      m_cnt = 0; m_cred = DEPTH; m_beats = 0; m_last = N - 1;
      exp_q.delete();
    end else begin
      exp_ack = m_on ? (4'b0001 << m_own) : 4'b0000;
      chk("ack", 32'(bus.ack), 32'(exp_ack));
      chk("count", 32'(count), m_cnt);
      chk("empty", 32'(empty), 32'(m_cnt == 0));
      chk("full", 32'(full), 32'(m_cnt == DEPTH));
      pop   = rd_en && (m_cnt > 0);
      push  = m_prev;
      grant = 1'b0;
      if (m_on) begin
        d = (data_q.size() > 0) ? data_q.pop_front() : 2'($urandom);
        exp_q.push_back({2'(m_own), d});
        drive_val = d;
      end else begin
        drive_val = 2'($urandom);
      end
      m_prev = m_on;
      if (m_on) begin
        if (bus.req[m_own] && m_beats < MAXB && m_cred >= 1) begin
          m_beats++;
          grant = 1'b1;
        end else begin
          m_on = 1'b0;
          m_drain = 1'b1;
        end
      end else if (m_drain) begin
        m_drain = 1'b0;
        m_last = m_own;
      end else if (bus.req != 4'b0000 && m_cred >= 1) begin
        for (int i = N; i >= 1; i--) begin
          k = (m_last + i) % N;
          if (bus.req[k]) m_own = k;
        end
        m_on = 1'b1;
        m_beats = 1;
        grant = 1'b1;
      end
      m_cnt  = m_cnt + int'(push) - int'(pop);
      m_cred = m_cred + int'(pop) - int'(grant);
    end
  end

  // pop monitor: every accepted pop must match the oldest expected beat
  always @(negedge clk) begin : monitor
    logic [3:0] e;
    if (!reset && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got id %0d data %0d expected no entry at %0t",
                 rd_id, rd_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", 32'(rd_data), 32'(e[1:0]));
        chk("rd_id", 32'(rd_id), 32'(e[3:2]));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int budget);
    int n;
    n = 0;
    while (bus.ack == 4'b0000 && n < budget) begin
      step(1);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack expected ack within %0d cycles", budget);
    end
  endtask

  initial begin
    reset = 1'b1;
    rd_en = 1'b0;
    bus.req = 4'b0000;
    step(3);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_id", 32'(rd_id), 32'd0);
    reset = 1'b0;
    step(2);

    // single master, known data, 4-beat tenure then re-grant after the gap
    data_q = '{2'd1, 2'd2, 2'd3, 2'd0};
    bus.req = 4'b0001;
    step(6);
    chk("t1_count", 32'(count), 32'd4);
    chk("t1_gap_ack", 32'(bus.ack), 32'd0);
    step(1);
    chk("t1_regrant", 32'(bus.ack), 32'h1);
    bus.req = 4'b0000;
    step(8);
    rd_en = 1'b1;
    step(12);

    // three masters round-robin, draining continuously
    bus.req = 4'b1011;
    step(45);
    bus.req = 4'b0000;
    step(20);

    // credit exhaustion with no draining
    rd_en = 1'b0;
    bus.req = 4'b0001;
    step(30);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_count", 32'(count), 32'd8);
    chk("t3_no_ack", 32'(bus.ack), 32'd0);
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    step(8);
    chk("t3_count_refill", 32'(count), 32'd8);
    chk("t3_full_refill", 32'(full), 32'd1);
    bus.req = 4'b0000;
    rd_en = 1'b1;
    step(12);

    // request dropped mid-tenure, then round-robin continues after master 2
    bus.req = 4'b0100;
    step(3);
    bus.req = 4'b0000;
    step(8);
    bus.req = 4'b1001;
    wait_ack(40);
    chk("t4_next_grant", 32'(bus.ack), 32'h8);
    bus.req = 4'b0000;
    step(10);

    // reset in the third ack cycle
    bus.req = 4'b0001;
    step(3);
    reset = 1'b1;
    #1;
    chk("t5_async_ack", 32'(bus.ack), 32'd0);
    bus.req = 4'b1111;
    step(2);
    reset = 1'b0;
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_empty", 32'(empty), 32'd1);
    wait_ack(40);
    chk("t5_first_grant", 32'(bus.ack), 32'h1);
    bus.req = 4'b0000;
    step(12);

    // pops on an empty FIFO, then simultaneous push and pop at count 5
    step(5);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_count0", 32'(count), 32'd0);
    rd_en = 1'b0;
    bus.req = 4'b0001;
    step(9);
    chk("t6_count5", 32'(count), 32'd5);
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    chk("t6_count_hold", 32'(count), 32'd5);
    bus.req = 4'b0000;
    step(6);
    rd_en = 1'b1;
    step(15);
    chk("t6_drained", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Target end of the 2-bit request/acknowledge bus driven by the Bus_Master blocks.
- Arbitrates round-robin among N_MASTERS request lines and asserts a one-hot ack to exactly one master per tenure.
- Captures each 2-bit beat the granted master drives onto the shared bus into a tagged FIFO; downstream logic drains the FIFO with a pop strobe.

Parameters:
- N_MASTERS, 4, number of requesting masters (2..8).
- DEPTH, 8, capture FIFO entries (power of two, ≥2).
- MAX_BEATS, 4, maximum ack cycles per tenure (≥1).
- ID_W, 2, owner-tag width, equal to clog2(N_MASTERS).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_MASTERS  req_out of each master; bit i belongs to master i.
- bus_data  in  2  shared data bus; driven by the acked master, Z otherwise.
- ack  out  N_MASTERS  registered one-hot grant, all zeros when idle.
- rd_en  in  1  pop strobe from downstream.
- rd_data  out  2  data field of the FIFO head.
- rd_id  out  ID_W  owner tag of the FIFO head.
- empty  out  1  FIFO holds 0 entries.
- full  out  1  FIFO holds DEPTH entries.
- count  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset:
  - ack=0, empty=1, full=0, count=0, rd_data=0, rd_id=0.
  - FIFO pointers cleared, FSM to IDLE, rr_ptr=N_MASTERS-1 so master 0 wins first.
  - credits=DEPTH, drive_q=0, beat_cnt=0.
  - Reset mid-tenure drops ack immediately and discards in-flight beats.
- Master timing: a master samples ack at an edge and drives bus_data in the following cycle. The beat for an ack cycle is therefore captured 2 edges after ack rises.
- Capture pipeline:
  - drive_q <= |ack each edge.
  - At every edge where drive_q=1, push {owner, bus_data}.
  - Captured beats always equal the number of cycles ack was high. The final beat arrives after ack has already fallen and must be captured.
- Credits:
  - credits = DEPTH − count − beats in flight.
  - Decrement by 1 at each edge that leaves ack high for the next cycle.
  - Increment by 1 on each accepted pop.
  - When a grant and a pop occur at the same edge, credits are unchanged.
  - ack may be raised or held only if credits ≥1 at that edge. This guarantees a push never finds the FIFO full.
- FSM:
  - IDLE:
    - If req≠0 and credits≥1, select the first set req bit scanning from rr_ptr+1 modulo N_MASTERS.
    - Set owner, ack[owner]=1, beat_cnt=1, go GRANT.
    - Otherwise hold.
  - GRANT (ack[owner]=1):
    - Hold while req[owner]=1, beat_cnt<MAX_BEATS and credits≥1, incrementing beat_cnt.
    - Otherwise ack<=0 and go DRAIN.
  - DRAIN:
    - One cycle: the last beat is captured at this edge.
    - rr_ptr<=owner, go IDLE.
    - No new grant is issued in DRAIN; this is the bus turnaround cycle.
  - Minimum gap between tenures: ack is low for ≥2 cycles.
- FIFO:
  - Head is first-word-fall-through: rd_data/rd_id are valid whenever empty=0.
  - Pop occurs on rd_en && !empty; rd_en while empty is ignored, with no pointer or credit change.
  - Push and pop at the same edge leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - count, full and empty are registered and consistent with each other.
- Other rules:
  - A req dropped during GRANT ends the tenure at the next edge. The beat already in flight is still captured.
  - A req bit for an unselected master has no effect on the current tenure.
  - ack is never multi-hot.
  - ack never goes to a master whose req was 0 at the deciding edge.

Test Plan:
- Reset, then req=4'b0001 held high for 10 cycles with bus_data=1,2,3,0 → ack[0] high for exactly 4 cycles; FIFO holds 4 entries {0,1},{0,2},{0,3},{0,0}; ack low ≥2 cycles; then master 0 is re-granted.
- req=4'b1011 held → grant order 0,1,3,0,1,3; each tenure is 4 beats; rd_id sequence matches that order as the bench drains with rd_en=1.
- rd_en=0, req=4'b0001, DEPTH=8 → exactly 8 ack cycles over two tenures; full=1 with count=8; no further ack; one pop re-enables a 1-cycle grant; count never exceeds 8.
- req[2] drops after 2 ack cycles → ack[2] falls on the next edge; 3 beats are captured (including the in-flight beat); rr_ptr=2, so the next grant favours master 3.
- Assert reset during the 3rd ack cycle → ack=0 immediately; count=0 and empty=1 after release; the first grant then goes to master 0.
- Empty FIFO with rd_en=1, plus simultaneous push and pop at count=5 → no change when empty; count stays 5 for the simultaneous case; data is ordered correctly across pointer wrap.
